// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receive stage: synchronizes rxd, samples mid-bit, and
// emits one-cycle strobes for good bytes, framing errors and glitches.
module uart_rx_deserializer #(
   parameter int CLK_FREQUENCY = 100_000_000,
   parameter int BAUD          = 12_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_error,
   output logic       glitch,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] T_HALF = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] T_BIT  = CW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 4) begin : g_rate_check
      $error("uart_rx_deserializer: CLKS_PER_BIT must be at least 4");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state;
   logic [1:0]      sync_q;
   logic            rxd_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_reg;

   assign rxd_s = sync_q[1];

   // Two-flop synchronizer; reloads to idle-high so reset never fakes a start.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rxd};
      end
   end

   // Receive FSM: start qualification, mid-bit sampling, stop check, break hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         data        <= '0;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
         glitch      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
         glitch      <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (!rxd_s) begin
                  state <= S_START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            S_START: begin
               if (cnt == T_HALF) begin
                  cnt <= '0;
                  if (!rxd_s) begin
                     state   <= S_DATA;
                     bit_idx <= '0;
                  end else begin
                     glitch <= 1'b1;
                     state  <= S_IDLE;
                     busy   <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == T_BIT) begin
                  cnt       <= '0;
                  shift_reg <= {rxd_s, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt == T_BIT) begin
                  cnt <= '0;
                  if (rxd_s) begin
                     data       <= shift_reg;
                     data_valid <= 1'b1;
                     state      <= S_IDLE;
                     busy       <= 1'b0;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= S_BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_BREAK: begin
               // A held-low line must return high before a new start counts.
               if (rxd_s) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed plus randomized bench for uart_rx_deserializer at 8 clk/bit;
// expected bytes and strobe cycles come from frame start times.
module tb_uart_rx_deserializer;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_error;
   logic       glitch;
   logic       busy;

   uart_rx_deserializer dut (
      .clk         (clk),
      .reset       (reset),
      .rxd         (rxd),
      .data        (data),
      .data_valid  (data_valid),
      .frame_error (frame_error),
      .glitch      (glitch),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Frame timing at the defaults: 8 clk/bit, mid-bit offset 4 plus 2 sync.
   localparam int DV_LAT = 2 + 4 + 9 * 8;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         cmp_n = 0;
   int         mis_n = 0;
   logic       busy_hist [4096];
   int         dv_cyc [$];
   logic [7:0] dv_dat [$];
   int         fe_cyc [$];
   int         gl_cyc [$];
   int         overlap = 0;
   int         consec = 0;
   bit         prev_strobe = 1'b0;

   // Record every strobe with the edge number that produced it.
   always @(negedge clk) begin
      int n;
      if (cyc < 4096) busy_hist[cyc] = busy;
      if (data_valid) begin
         dv_cyc.push_back(cyc);
         dv_dat.push_back(data);
      end
      if (frame_error) fe_cyc.push_back(cyc);
      if (glitch) gl_cyc.push_back(cyc);
      n = int'(data_valid) + int'(frame_error) + int'(glitch);
      if (n > 1) overlap++;
      if (n > 0 && prev_strobe) consec++;
      prev_strobe = (n > 0);
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      cmp_n++;
      assert (got === exp)
      else begin
         mis_n++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic line(input logic v, input int n);
      rxd = v;
      repeat (n) @(negedge clk);
   endtask

   // Drive one 8N1 frame with a bit period of p10/10 clocks; len truncates.
   task automatic frame(input logic [7:0] b, input int p10,
                        input logic stop_v, input int len,
                        output int e0);
      int t;
      int k;
      e0 = cyc + 1;
      t = 0;
      k = 0;
      while (k < 10 && t < len) begin
         if (k == 0) rxd = 1'b0;
         else if (k == 9) rxd = stop_v;
         else rxd = b[k-1];
         @(negedge clk);
         t++;
         k = (t * 10) / p10;
      end
   endtask

   task automatic pop_dv(output logic [31:0] c, output logic [31:0] d);
      if (dv_cyc.size() == 0) begin
         c = '1;
         d = '1;
      end else begin
         c = dv_cyc.pop_front();
         d = {24'd0, dv_dat.pop_front()};
      end
   endtask

   task automatic clear_q();
      dv_cyc.delete();
      dv_dat.delete();
      fe_cyc.delete();
      gl_cyc.delete();
   endtask

   initial begin
      int e0;
      int e1;
      int eb [4];
      logic [7:0] vb [4];
      int rq_e [$];
      logic [7:0] rq_b [$];
      logic [31:0] gc;
      logic [31:0] gd;

      rxd = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data", {24'd0, data}, 32'h00);
      chk("rst_dv", {31'd0, data_valid}, 0);
      chk("rst_fe", {31'd0, frame_error}, 0);
      chk("rst_glitch", {31'd0, glitch}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      reset = 1'b0;
      line(1'b1, 5);
      clear_q();

      // Single frame 0xA5.
      frame(8'hA5, 80, 1'b1, 100, e0);
      line(1'b1, 12);
      chk("a5_dv_count", dv_cyc.size(), 1);
      pop_dv(gc, gd);
      chk("a5_dv_cycle", gc, e0 + DV_LAT);
      chk("a5_data", gd, 32'hA5);
      chk("a5_busy_pre", {31'd0, busy_hist[e0+1]}, 0);
      chk("a5_busy_on", {31'd0, busy_hist[e0+2]}, 1);
      chk("a5_busy_last", {31'd0, busy_hist[e0+77]}, 1);
      chk("a5_busy_off", {31'd0, busy_hist[e0+78]}, 0);
      chk("a5_fe_count", fe_cyc.size(), 0);
      chk("a5_gl_count", gl_cyc.size(), 0);
      clear_q();

      // Four frames with zero idle bits.
      vb[0] = 8'h00;
      vb[1] = 8'hFF;
      vb[2] = 8'h55;
      vb[3] = 8'h80;
      for (int i = 0; i < 4; i++) frame(vb[i], 80, 1'b1, 100, eb[i]);
      line(1'b1, 12);
      chk("b2b_dv_count", dv_cyc.size(), 4);
      for (int i = 0; i < 4; i++) begin
         pop_dv(gc, gd);
         chk($sformatf("b2b_cycle%0d", i), gc, eb[0] + 80 * i + DV_LAT);
         chk($sformatf("b2b_data%0d", i), gd, {24'd0, vb[i]});
      end
      clear_q();

      // Three-clock low pulse is a glitch.
      e0 = cyc + 1;
      line(1'b0, 3);
      line(1'b1, 20);
      chk("gl_count", gl_cyc.size(), 1);
      chk("gl_cycle", gl_cyc.size() > 0 ? gl_cyc[0] : -1, e0 + 6);
      chk("gl_no_dv", dv_cyc.size(), 0);
      chk("gl_data_kept", {24'd0, data}, 32'h80);
      chk("gl_busy_off", {31'd0, busy_hist[e0+7]}, 0);
      clear_q();

      // Low stop bit, held break, then a good frame.
      frame(8'h3C, 80, 1'b0, 100, e0);
      line(1'b0, 40);
      line(1'b1, 10);
      frame(8'h12, 80, 1'b1, 100, e1);
      line(1'b1, 12);
      chk("fe_count", fe_cyc.size(), 1);
      chk("fe_cycle", fe_cyc.size() > 0 ? fe_cyc[0] : -1, e0 + DV_LAT);
      chk("fe_gl_count", gl_cyc.size(), 0);
      chk("fe_busy_hold", {31'd0, busy_hist[e0+110]}, 1);
      chk("fe_busy_idle", {31'd0, busy_hist[e0+126]}, 0);
      chk("fe_dv_count", dv_cyc.size(), 1);
      pop_dv(gc, gd);
      chk("fe_next_cycle", gc, e1 + DV_LAT);
      chk("fe_next_data", gd, 32'h12);
      clear_q();

      // Reset in the middle of bit 4 aborts the frame silently.
      frame(8'h96, 80, 1'b1, 44, e0);
      reset = 1'b1;
      rxd = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_busy", {31'd0, busy}, 0);
      chk("rst_mid_data", {24'd0, data}, 32'h00);
      line(1'b1, 10);
      frame(8'h69, 80, 1'b1, 100, e1);
      line(1'b1, 12);
      chk("rst_mid_fe", fe_cyc.size(), 0);
      chk("rst_mid_gl", gl_cyc.size(), 0);
      chk("rst_mid_dv_count", dv_cyc.size(), 1);
      pop_dv(gc, gd);
      chk("rst_mid_cycle", gc, e1 + DV_LAT);
      chk("rst_mid_data69", gd, 32'h69);
      clear_q();

      // Off-nominal bit periods of 7.6 and 8.4 clocks.
      frame(8'hC3, 76, 1'b1, 100, e0);
      line(1'b1, 16);
      frame(8'hC3, 84, 1'b1, 100, e1);
      line(1'b1, 16);
      chk("baud_dv_count", dv_cyc.size(), 2);
      pop_dv(gc, gd);
      chk("baud_fast_data", gd, 32'hC3);
      pop_dv(gc, gd);
      chk("baud_slow_data", gd, 32'hC3);
      chk("baud_fe_count", fe_cyc.size(), 0);
      clear_q();

      // Random bytes with random idle gaps of 0..4 clocks.
      for (int i = 0; i < 8; i++) begin
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         frame(b, 80, 1'b1, 100, e0);
         rq_e.push_back(e0);
         rq_b.push_back(b);
         line(1'b1, $urandom_range(0, 4));
      end
      line(1'b1, 12);
      chk("rnd_dv_count", dv_cyc.size(), 8);
      for (int i = 0; i < 8; i++) begin
         pop_dv(gc, gd);
         chk($sformatf("rnd_cycle%0d", i), gc, rq_e[i] + DV_LAT);
         chk($sformatf("rnd_data%0d", i), gd, {24'd0, rq_b[i]});
      end
      chk("rnd_fe_count", fe_cyc.size(), 0);
      chk("rnd_gl_count", gl_cyc.size(), 0);

      chk("strobe_overlap", overlap, 0);
      chk("strobe_consecutive", consec, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
      $finish;
   end

endmodule
